// File: rtl/branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// branch_predictor_gshare
//
// Branch predictor built from a pattern history table (PHT) of 2-bit
// saturating counters and a direct-mapped branch target buffer (BTB).
// MODE 0 indexes the PHT with PC bits only (bimodal). MODE 1 XORs those PC
// bits with the global history register (gshare). The BTB is always indexed
// by PC bits only.
//
// After reset an INIT sweep writes every PHT entry to weakly-not-taken and
// clears every BTB valid bit, one index per cycle. ready then rises and the
// predictor starts serving predictions and accepting updates.
//
// Ports
//   sysclk      : clock; all state changes on the rising edge
//   rst         : synchronous active-high reset (restarts the INIT sweep)
//   ready       : high once the INIT sweep has finished
//   fetch_pc    : PC being fetched this cycle
//   pred_taken  : predict a redirect to pred_target
//   pred_target : BTB target on a hit, otherwise fetch_pc + 4
//   pred_hit    : BTB tag match for fetch_pc
//   pred_ghr    : history value used for this prediction
//   upd_valid   : resolved control-flow update strobe
//   upd_pc      : PC of the resolved instruction
//   upd_is_br   : 1 = conditional branch, 0 = unconditional jump
//   upd_taken   : resolved direction
//   upd_target  : resolved target
//   upd_ghr     : pred_ghr value that travelled with the instruction
// ---------------------------------------------------------------------------
module branch_predictor_gshare #(
    parameter int IDX_W = 8,
    parameter int GHR_W = 8,
    parameter int TAG_W = 8,
    parameter int MODE  = 1
) (
    input  logic             sysclk,
    input  logic             rst,
    output logic             ready,
    input  logic [31:0]      fetch_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic             pred_hit,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_is_br,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic [GHR_W-1:0] upd_ghr
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] init_idx_reg;
    logic [GHR_W-1:0] ghr_reg;
    logic [GHR_W-1:0] ghr_next;

    logic [1:0]       pht_mem        [DEPTH];
    logic             btb_valid_mem  [DEPTH];
    logic             btb_jump_mem   [DEPTH];
    logic [TAG_W-1:0] btb_tag_mem    [DEPTH];
    logic [31:0]      btb_target_mem [DEPTH];

    logic [IDX_W-1:0] fetch_btb_idx;
    logic [IDX_W-1:0] fetch_pht_idx;
    logic [IDX_W-1:0] upd_btb_idx;
    logic [IDX_W-1:0] upd_pht_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [TAG_W-1:0] upd_tag;

    logic             fetch_entry_match;
    logic [1:0]       pht_cur;
    logic [1:0]       pht_next;

    // Only a slice of each PC (and, in bimodal mode, none of upd_ghr) is
    // consumed; this reduction keeps the remaining bits formally referenced.
    logic             unused_bits;
    assign unused_bits = ^{fetch_pc, upd_pc, upd_ghr};

    assign fetch_btb_idx = fetch_pc[IDX_W+1:2];
    assign upd_btb_idx   = upd_pc[IDX_W+1:2];
    assign fetch_tag     = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_tag       = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // The update side hashes with the history the instruction was predicted
    // under (upd_ghr), not the live register, so it trains the same counter
    // the prediction read.
    generate
        if (MODE == 0) begin : g_bimodal
            assign fetch_pht_idx = fetch_btb_idx;
            assign upd_pht_idx   = upd_btb_idx;
        end else begin : g_gshare
            assign fetch_pht_idx = fetch_btb_idx ^ IDX_W'(ghr_reg);
            assign upd_pht_idx   = upd_btb_idx ^ IDX_W'(upd_ghr);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Prediction: purely combinational reads, so a same-cycle update is seen
    // only from the next cycle on.
    // -----------------------------------------------------------------------
    assign ready             = (state_reg == ST_RUN);
    assign fetch_entry_match = btb_valid_mem[fetch_btb_idx] &&
                               (btb_tag_mem[fetch_btb_idx] == fetch_tag);
    assign pred_hit          = ready && fetch_entry_match;
    assign pred_target       = pred_hit ? btb_target_mem[fetch_btb_idx]
                                        : fetch_pc + 32'd4;
    assign pred_taken        = pred_hit &&
                               (btb_jump_mem[fetch_btb_idx] || pht_mem[fetch_pht_idx][1]);
    assign pred_ghr          = ghr_reg;

    // Saturating counter step for the entry being trained.
    always_comb begin
        pht_cur  = pht_mem[upd_pht_idx];
        pht_next = pht_cur;
        if (upd_taken) begin
            if (pht_cur != 2'b11) begin
                pht_next = pht_cur + 2'd1;
            end
        end else if (pht_cur != 2'b00) begin
            pht_next = pht_cur - 2'd1;
        end
    end

    // Shift in the newest outcome at bit 0; the oldest bit falls off the top.
    assign ghr_next = GHR_W'({ghr_reg, upd_taken});

    // -----------------------------------------------------------------------
    // Control: INIT sweep counter, state and global history.
    // -----------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_reg    <= ST_INIT;
            init_idx_reg <= '0;
            ghr_reg      <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    init_idx_reg <= init_idx_reg + IDX_W'(1);
                    if (init_idx_reg == '1) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (upd_valid && upd_is_br) begin
                        ghr_reg <= ghr_next;
                    end
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Table writes. Contents are left alone while rst is high; the sweep that
    // follows release puts them into a known state.
    // -----------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (!rst) begin
            if (state_reg == ST_INIT) begin
                pht_mem[init_idx_reg]       <= 2'b01;
                btb_valid_mem[init_idx_reg] <= 1'b0;
            end else if (upd_valid) begin
                // Jumps never train direction state.
                if (upd_is_br) begin
                    pht_mem[upd_pht_idx] <= pht_next;
                end
                // Any taken transfer claims its BTB slot, evicting whatever
                // alias was there.
                if (upd_taken) begin
                    btb_valid_mem[upd_btb_idx]  <= 1'b1;
                    btb_jump_mem[upd_btb_idx]   <= ~upd_is_br;
                    btb_tag_mem[upd_btb_idx]    <= upd_tag;
                    btb_target_mem[upd_btb_idx] <= upd_target;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_gshare
//
// Drives a gshare instance (index 0) and a bimodal instance (index 1) with
// identical stimulus and checks both against a table-level reference model:
// per-entry counters, BTB records and a history integer updated by the
// predictor's rules, plus a count of clock edges since reset release.
// ---------------------------------------------------------------------------
module tb_branch_predictor_gshare;

    logic        sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic        rst;
    logic [31:0] fetch_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_br;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [7:0]  upd_ghr;

    logic [1:0]        rdy;
    logic [1:0]        pt;
    logic [1:0]        ph;
    logic [1:0][31:0]  ptg;
    logic [1:0][7:0]   pg;

    int n_cmp = 0;
    int n_bad = 0;

    branch_predictor_gshare #(.IDX_W(8), .GHR_W(8), .TAG_W(8), .MODE(1)) dut_gshare (
        .sysclk(sysclk), .rst(rst), .ready(rdy[0]), .fetch_pc(fetch_pc),
        .pred_taken(pt[0]), .pred_target(ptg[0]), .pred_hit(ph[0]), .pred_ghr(pg[0]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr)
    );

    branch_predictor_gshare #(.IDX_W(8), .GHR_W(8), .TAG_W(8), .MODE(0)) dut_bimodal (
        .sysclk(sysclk), .rst(rst), .ready(rdy[1]), .fetch_pc(fetch_pc),
        .pred_taken(pt[1]), .pred_target(ptg[1]), .pred_hit(ph[1]), .pred_ghr(pg[1]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr)
    );

    // ---------------- reference model ----------------
    int          cnt;            // edges since reset release
    int          m_ghr;          // 0..255
    int          m_pht [2][256];
    bit          m_val [2][256];
    bit          m_jmp [2][256];
    int          m_tag [2][256];
    logic [31:0] m_tgt [2][256];

    task automatic model_edge();
        int pi, gi, ug;
        if (rst) begin
            cnt   = 0;
            m_ghr = 0;
        end else if (cnt < 256) begin
            cnt++;
            if (cnt == 256) begin
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < 256; i++) begin
                        m_pht[k][i] = 1;
                        m_val[k][i] = 0;
                    end
            end
        end else if (upd_valid) begin
            pi = int'((upd_pc >> 2) & 32'hFF);
            ug = int'(upd_ghr);
            for (int k = 0; k < 2; k++) begin
                if (upd_is_br) begin
                    gi = (k == 0) ? (pi ^ ug) : pi;
                    if (upd_taken) m_pht[k][gi] = (m_pht[k][gi] < 3) ? m_pht[k][gi] + 1 : 3;
                    else           m_pht[k][gi] = (m_pht[k][gi] > 0) ? m_pht[k][gi] - 1 : 0;
                end
                if (upd_taken) begin
                    m_val[k][pi] = 1;
                    m_jmp[k][pi] = !upd_is_br;
                    m_tag[k][pi] = int'((upd_pc >> 10) & 32'hFF);
                    m_tgt[k][pi] = upd_target;
                end
            end
            if (upd_is_br) m_ghr = ((m_ghr << 1) | int'(upd_taken)) & 255;
        end
    endtask

    task automatic model_pred(input int k, input logic [31:0] pc,
                              output logic e_taken, output logic e_hit,
                              output logic [31:0] e_tgt);
        int pi, gi, tg;
        pi = int'((pc >> 2) & 32'hFF);
        tg = int'((pc >> 10) & 32'hFF);
        gi = (k == 0) ? (pi ^ m_ghr) : pi;
        e_hit   = (cnt >= 256) && m_val[k][pi] && (m_tag[k][pi] == tg);
        e_tgt   = e_hit ? m_tgt[k][pi] : pc + 32'd4;
        e_taken = e_hit && (m_jmp[k][pi] || m_pht[k][gi] >= 2);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge sysclk);
        model_edge();
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic br, input logic tk,
                       input logic [31:0] tg);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_is_br  = br;
        upd_taken  = tk;
        upd_target = tg;
        upd_ghr    = 8'(m_ghr);
        $display("upd pc=%h br=%0d taken=%0d target=%h ghr=%h", pc, br, tk, tg, upd_ghr);
        step();
        upd_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; upd_valid = 1'b0; fetch_pc = 32'h0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (rdy[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_ready_low inst%0d cyc%0d: got %b, expected 0", k, i, rdy[k]);
                end
            end
            // updates during INIT must leave no trace
            upd_valid = 1'($urandom_range(0, 1));
            upd_pc = 32'h100; upd_is_br = 1'b1; upd_taken = 1'b1;
            upd_target = 32'hDEAD0; upd_ghr = 8'h00;
            step();
        end
        upd_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            fetch_pc = (j == 0) ? 32'h100 : ($urandom & 32'hFFFF_FFFC);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (rdy[k] !== 1'b1 || ph[k] !== 1'b0 || pt[k] !== 1'b0 || ptg[k] !== fetch_pc + 32'd4) begin
                    n_bad++;
                    $display("FAIL reset_clean inst%0d pc=%h: got rdy=%b hit=%b tk=%b tgt=%h, expected 1 0 0 %h",
                             k, fetch_pc, rdy[k], ph[k], pt[k], ptg[k], fetch_pc + 32'd4);
                end
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_mode0_counter();
        logic et, eh; logic [31:0] etg;
        upd(32'h100, 1'b1, 1'b1, 32'h80);
        upd(32'h100, 1'b1, 1'b1, 32'h80);
        fetch_pc = 32'h100; #1;
        n_cmp++;
        if (pt[1] !== 1'b1 || ptg[1] !== 32'h80 || ph[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL bimodal_taken: got tk=%b tgt=%h hit=%b, expected 1 00000080 1", pt[1], ptg[1], ph[1]);
        end
        for (int i = 0; i < 3; i++) upd(32'h100, 1'b1, 1'b0, 32'h80);
        fetch_pc = 32'h100; #1;
        n_cmp++;
        if (pt[1] !== 1'b0 || ph[1] !== 1'b1 || ptg[1] !== 32'h80) begin
            n_bad++;
            $display("FAIL bimodal_not_taken: got tk=%b hit=%b tgt=%h, expected 0 1 00000080", pt[1], ph[1], ptg[1]);
        end
        for (int k = 0; k < 2; k++) begin
            model_pred(k, fetch_pc, et, eh, etg);
            n_cmp++;
            if (pt[k] !== et) begin
                n_bad++;
                $display("FAIL counter_model inst%0d: got %b, expected %b", k, pt[k], et);
            end
        end
    endtask

    task automatic test_jump();
        logic [7:0] g0;
        g0 = 8'(m_ghr);
        upd(32'h200, 1'b0, 1'b1, 32'h400);
        fetch_pc = 32'h200; #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (pt[k] !== 1'b1 || ptg[k] !== 32'h400 || pg[k] !== g0) begin
                n_bad++;
                $display("FAIL jump inst%0d: got tk=%b tgt=%h ghr=%h, expected 1 00000400 %h", k, pt[k], ptg[k], pg[k], g0);
            end
        end
    endtask

    task automatic test_tag_alias();
        upd(32'h100, 1'b1, 1'b1, 32'h1110);
        upd(32'h500, 1'b1, 1'b1, 32'h2220);
        fetch_pc = 32'h100; #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ph[k] !== 1'b0 || ptg[k] !== 32'h104) begin
                n_bad++;
                $display("FAIL alias_old inst%0d: got hit=%b tgt=%h, expected 0 00000104", k, ph[k], ptg[k]);
            end
        end
        fetch_pc = 32'h500; #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ph[k] !== 1'b1 || ptg[k] !== 32'h2220) begin
                n_bad++;
                $display("FAIL alias_new inst%0d: got hit=%b tgt=%h, expected 1 00002220", k, ph[k], ptg[k]);
            end
        end
    endtask

    task automatic test_same_cycle();
        fetch_pc   = 32'h700;
        upd_valid  = 1'b1; upd_pc = 32'h700; upd_is_br = 1'b0;
        upd_taken  = 1'b1; upd_target = 32'h900; upd_ghr = 8'(m_ghr);
        #1;
        $display("upd pc=%h br=0 taken=1 target=%h (same-cycle fetch)", upd_pc, upd_target);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ph[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL same_cycle_pre inst%0d: got hit=%b, expected 0", k, ph[k]);
            end
        end
        step();
        upd_valid = 1'b0; #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ph[k] !== 1'b1 || ptg[k] !== 32'h900) begin
                n_bad++;
                $display("FAIL same_cycle_post inst%0d: got hit=%b tgt=%h, expected 1 00000900", k, ph[k], ptg[k]);
            end
        end
    endtask

    task automatic test_ghr_hash();
        logic [7:0] pat;
        rst = 1'b1; step(); rst = 1'b0;
        n_cmp++;
        if (rdy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL run_reset_drop: got %b, expected 0", rdy[0]);
        end
        for (int i = 0; i < 256; i++) step();
        upd(32'h300, 1'b1, 1'b1, 32'h3000);
        upd(32'h300, 1'b1, 1'b1, 32'h3000);
        upd(32'h300, 1'b1, 1'b0, 32'h3000);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (pg[k] !== 8'h06) begin
                n_bad++;
                $display("FAIL ghr_value inst%0d: got %h, expected 06", k, pg[k]);
            end
        end
        // trains gshare PHT[0x40 ^ 0x06 = 0x46] to 2
        upd(32'h100, 1'b1, 1'b1, 32'h1000);
        // walk history back to 0x06 so a fetch of 0x100 reads index 0x46
        pat = 8'b0000_0110;
        for (int b = 7; b >= 0; b--) upd(32'h300, 1'b1, pat[b], 32'h3000);
        fetch_pc = 32'h100; #1;
        n_cmp++;
        if (pt[0] !== 1'b1 || ph[0] !== 1'b1 || ptg[0] !== 32'h1000 || pg[0] !== 8'h06) begin
            n_bad++;
            $display("FAIL ghr_hash_idx: got tk=%b hit=%b tgt=%h ghr=%h, expected 1 1 00001000 06", pt[0], ph[0], ptg[0], pg[0]);
        end
    endtask

    task automatic test_random();
        logic et, eh; logic [31:0] etg;
        for (int c = 0; c < 600; c++) begin
            fetch_pc   = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
            upd_valid  = ($urandom_range(0, 1) == 1);
            upd_pc     = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
            upd_is_br  = ($urandom_range(0, 4) != 0);
            upd_taken  = 1'($urandom_range(0, 1));
            upd_target = $urandom & 32'hFFFF_FFFC;
            upd_ghr    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(m_ghr);
            #1;
            for (int k = 0; k < 2; k++) begin
                model_pred(k, fetch_pc, et, eh, etg);
                n_cmp++;
                if (rdy[k] !== 1'b1 || pt[k] !== et || ph[k] !== eh || ptg[k] !== etg || pg[k] !== 8'(m_ghr)) begin
                    n_bad++;
                    $display("FAIL random inst%0d cyc%0d pc=%h: got rdy=%b tk=%b hit=%b tgt=%h ghr=%h, expected 1 %b %b %h %h",
                             k, c, fetch_pc, rdy[k], pt[k], ph[k], ptg[k], pg[k], et, eh, etg, 8'(m_ghr));
                end
            end
            if (upd_valid)
                $display("upd pc=%h br=%0d taken=%0d target=%h ghr=%h", upd_pc, upd_is_br, upd_taken, upd_target, upd_ghr);
            step();
        end
        upd_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            upd_valid = 1'($urandom_range(0, 1));
            upd_pc = 32'h100; upd_is_br = 1'b0; upd_taken = 1'b1; upd_target = 32'hBAD0;
            step();
        end
        upd_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (rdy[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL mid_reset_ready_low inst%0d cyc%0d: got %b, expected 0", k, i, rdy[k]);
                end
            end
            upd_valid = 1'($urandom_range(0, 1));
            step();
        end
        upd_valid = 1'b0;
        fetch_pc = 32'h100; #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rdy[k] !== 1'b1 || ph[k] !== 1'b0 || pt[k] !== 1'b0 || ptg[k] !== 32'h104 || pg[k] !== 8'h00) begin
                n_bad++;
                $display("FAIL mid_reset_clean inst%0d: got rdy=%b hit=%b tk=%b tgt=%h ghr=%h, expected 1 0 0 00000104 00",
                         k, rdy[k], ph[k], pt[k], ptg[k], pg[k]);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        rst = 1'b1; fetch_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_is_br = 1'b0; upd_taken = 1'b0; upd_target = '0; upd_ghr = '0;
        cnt = 0; m_ghr = 0;
        test_reset();
        test_mode0_counter();
        test_jump();
        test_tag_alias();
        test_same_cycle();
        test_ghr_hash();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
